// File: rtl/neopix_frame_pkg.sv
// Shared types and constants for the SPI-to-NeoPixel frame controller.
package neopix_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PIX,
        CSUM,
        COMMIT,
        WAIT_TX,
        DISCARD
    } state_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    localparam logic [1:0] ERR_BUSY_DROP = 2'd0;
    localparam logic [1:0] ERR_BAD_LEN   = 2'd1;
    localparam logic [1:0] ERR_ABORT     = 2'd2;
    localparam logic [1:0] ERR_CHECKSUM  = 2'd3;

    typedef logic [23:0] pixel_t;

endpackage

// File: rtl/pixel_packer.sv
// Packs three consecutive bytes (G, R, B) into one pixel word and issues a
// registered write strobe when the third byte of a pixel arrives.
module pixel_packer
    import neopix_frame_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [7:0]        data,
    input  logic [ADDR_W-1:0] idx,
    output logic              last,
    output logic              pix_we,
    output logic [ADDR_W-1:0] pix_addr,
    output pixel_t            pix_wdata
);

    logic [1:0]  byte_idx;
    logic [15:0] shift;

    // The FSM uses this to detect that the byte being offered completes a pixel.
    assign last = (byte_idx == 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx  <= 2'd0;
            shift     <= 16'd0;
            pix_we    <= 1'b0;
            pix_addr  <= '0;
            pix_wdata <= '0;
        end else begin
            pix_we <= 1'b0;
            if (clr) begin
                byte_idx <= 2'd0;
            end else if (en) begin
                shift <= {shift[7:0], data};
                if (last) begin
                    byte_idx  <= 2'd0;
                    pix_we    <= 1'b1;
                    pix_addr  <= idx;
                    pix_wdata <= {shift, data};
                end else begin
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_frame_ctrl.sv
// Parses SPI bytes into pixel frames and hands complete frames to the NeoPixel
// transmitter. Define FRAME_CHECKSUM_EN to require a trailing XOR checksum byte.
module spi_frame_ctrl
    import neopix_frame_pkg::*;
#(
    parameter int         MAX_PIXELS = 64,
    parameter int         ADDR_W     = 6,
    parameter logic [7:0] HEADER     = HEADER_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              frame_active,
    output logic              pix_we,
    output logic [ADDR_W-1:0] pix_addr,
    output pixel_t            pix_wdata,
    output logic              tx_start,
    output logic [ADDR_W:0]   tx_len,
    input  logic              tx_busy,
    output logic              frame_err,
    output logic [1:0]        err_code
);

    localparam int                LEN_W   = ADDR_W + 1;
    localparam logic [LEN_W-1:0]  LEN_ONE = 1;
    localparam logic [ADDR_W-1:0] IDX_ONE = 1;

    state_t            state, state_n;
    logic [LEN_W-1:0]  len, len_n;
    logic [ADDR_W-1:0] pix_idx, idx_n;
    logic              tx_start_n;
    logic [LEN_W-1:0]  tx_len_n;
    logic              frame_err_n;
    logic [1:0]        err_code_n;
    logic              pack_clr, pack_en, pack_last;
    logic              last_pixel;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]        csum, csum_n;
`endif

    assign last_pixel = ({1'b0, pix_idx} == (len - LEN_ONE));

    pixel_packer #(.ADDR_W(ADDR_W)) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pack_clr),
        .en        (pack_en),
        .data      (rx_data),
        .idx       (pix_idx),
        .last      (pack_last),
        .pix_we    (pix_we),
        .pix_addr  (pix_addr),
        .pix_wdata (pix_wdata)
    );

    always_comb begin
        state_n     = state;
        len_n       = len;
        idx_n       = pix_idx;
        tx_start_n  = tx_start;
        tx_len_n    = tx_len;
        frame_err_n = 1'b0;
        err_code_n  = err_code;
        pack_clr    = 1'b0;
        pack_en     = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        csum_n      = csum;
`endif
        case (state)
            IDLE: begin
                if (rx_ready && rx_data == HEADER) state_n = LEN;
            end
            LEN: begin
                if (!frame_active) begin
                    frame_err_n = 1'b1;
                    err_code_n  = ERR_ABORT;
                    state_n     = IDLE;
                end else if (rx_ready) begin
                    if (rx_data != 8'd0 && int'(rx_data) <= MAX_PIXELS) begin
                        len_n    = LEN_W'(rx_data);
                        idx_n    = '0;
                        pack_clr = 1'b1;
`ifdef FRAME_CHECKSUM_EN
                        csum_n   = rx_data;
`endif
                        state_n  = PIX;
                    end else begin
                        frame_err_n = 1'b1;
                        err_code_n  = ERR_BAD_LEN;
                        state_n     = DISCARD;
                    end
                end
            end
            // Abort outranks a byte arriving in the same cycle; that byte is dropped.
            PIX: begin
                if (!frame_active) begin
                    frame_err_n = 1'b1;
                    err_code_n  = ERR_ABORT;
                    state_n     = IDLE;
                end else if (rx_ready) begin
                    pack_en = 1'b1;
`ifdef FRAME_CHECKSUM_EN
                    csum_n  = csum ^ rx_data;
`endif
                    if (pack_last) begin
                        if (last_pixel) begin
`ifdef FRAME_CHECKSUM_EN
                            state_n    = CSUM;
`else
                            state_n    = COMMIT;
                            tx_start_n = 1'b1;
                            tx_len_n   = len;
`endif
                        end else begin
                            idx_n = pix_idx + IDX_ONE;
                        end
                    end
                end
            end
`ifdef FRAME_CHECKSUM_EN
            CSUM: begin
                if (!frame_active) begin
                    frame_err_n = 1'b1;
                    err_code_n  = ERR_ABORT;
                    state_n     = IDLE;
                end else if (rx_ready) begin
                    if (rx_data == csum) begin
                        state_n    = COMMIT;
                        tx_start_n = 1'b1;
                        tx_len_n   = len;
                    end else begin
                        frame_err_n = 1'b1;
                        err_code_n  = ERR_CHECKSUM;
                        state_n     = IDLE;
                    end
                end
            end
`endif
            COMMIT: begin
                if (tx_busy) begin
                    tx_start_n = 1'b0;
                    state_n    = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (!tx_busy) begin
                    state_n = IDLE;
                end else if (rx_ready && rx_data == HEADER) begin
                    frame_err_n = 1'b1;
                    err_code_n  = ERR_BUSY_DROP;
                    state_n     = DISCARD;
                end
            end
            DISCARD: begin
                if (!frame_active) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            len       <= '0;
            pix_idx   <= '0;
            tx_start  <= 1'b0;
            tx_len    <= '0;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
`ifdef FRAME_CHECKSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            state     <= state_n;
            len       <= len_n;
            pix_idx   <= idx_n;
            tx_start  <= tx_start_n;
            tx_len    <= tx_len_n;
            frame_err <= frame_err_n;
            err_code  <= err_code_n;
`ifdef FRAME_CHECKSUM_EN
            csum      <= csum_n;
`endif
        end
    end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Scoreboard bench for spi_frame_ctrl: stimulus pushes expected writes, errors
// and transmit requests; a negedge monitor pops and compares them.
module tb_spi_frame_ctrl;

    localparam logic [7:0] HDR = 8'hA5;

    typedef struct {
        logic [5:0]  addr;
        logic [23:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready = 1'b0;
    logic        frame_active = 1'b1;
    logic        pix_we;
    logic [5:0]  pix_addr;
    logic [23:0] pix_wdata;
    logic        tx_start;
    logic [6:0]  tx_len;
    logic        tx_busy = 1'b0;
    logic        frame_err;
    logic [1:0]  err_code;

    int checks = 0;
    int failures = 0;

    wr_t        wq[$];
    logic [1:0] eq[$];
    logic [6:0] tq[$];
    logic [7:0] pb[$];

    wr_t        m_wr;
    logic [1:0] m_err;
    logic [6:0] m_len;
    logic       prev_start = 1'b0;

    always #5 clk = ~clk;

    spi_frame_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .frame_active (frame_active),
        .pix_we       (pix_we),
        .pix_addr     (pix_addr),
        .pix_wdata    (pix_wdata),
        .tx_start     (tx_start),
        .tx_len       (tx_len),
        .tx_busy      (tx_busy),
        .frame_err    (frame_err),
        .err_code     (err_code)
    );

    // Monitor: every DUT event must match the head of its queue.
    always @(negedge clk) begin
        if (pix_we) begin
            checks++;
            if (wq.size() == 0) begin
                failures++;
                $display("FAIL pix_write unexpected: got addr=%0d data=%06h, required none", pix_addr, pix_wdata);
            end else begin
                m_wr = wq.pop_front();
                if (pix_addr !== m_wr.addr || pix_wdata !== m_wr.data) begin
                    failures++;
                    $display("FAIL pix_write: got addr=%0d data=%06h, required addr=%0d data=%06h",
                             pix_addr, pix_wdata, m_wr.addr, m_wr.data);
                end
            end
        end
        if (frame_err) begin
            checks++;
            if (eq.size() == 0) begin
                failures++;
                $display("FAIL frame_err unexpected: got code=%0d, required none", err_code);
            end else begin
                m_err = eq.pop_front();
                if (err_code !== m_err) begin
                    failures++;
                    $display("FAIL err_code: got %0d, required %0d", err_code, m_err);
                end
            end
        end
        if (tx_start && !prev_start) begin
            checks++;
            if (tq.size() == 0) begin
                failures++;
                $display("FAIL tx_start unexpected: got len=%0d, required none", tx_len);
            end else begin
                m_len = tq.pop_front();
                if (tx_len !== m_len) begin
                    failures++;
                    $display("FAIL tx_len: got %0d, required %0d", tx_len, m_len);
                end
            end
        end
        prev_start = tx_start;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic drop_select();
        frame_active = 1'b0;
        @(negedge clk);
        frame_active = 1'b1;
        @(negedge clk);
    endtask

    // Sends header, length, pb (3n bytes) and checksum if enabled; expects commit.
    task automatic good_frame(input int n);
        logic [7:0] cs;
        cs = n[7:0];
        for (int i = 0; i < n; i++) begin
            wq.push_back(wr_t'{addr: i[5:0], data: {pb[3*i], pb[3*i+1], pb[3*i+2]}});
        end
        foreach (pb[k]) cs ^= pb[k];
        tq.push_back(n[6:0]);
        send(HDR);
        send(n[7:0]);
        foreach (pb[k]) send(pb[k]);
`ifdef FRAME_CHECKSUM_EN
        send(cs);
`endif
        check("tx_start_after_last_byte", {31'd0, tx_start}, 32'd1);
        pb.delete();
    endtask

    task automatic serve_tx();
        int t;
        t = 0;
        while (!tx_start && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("tx_start_wait", {31'd0, tx_start}, 32'd1);
        repeat (2) @(negedge clk);
        check("tx_start_held", {31'd0, tx_start}, 32'd1);
        tx_busy = 1'b1;
        @(negedge clk);
        check("tx_start_drop_on_busy", {31'd0, tx_start}, 32'd0);
        repeat (3) @(negedge clk);
        tx_busy = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_pix_we"},    {31'd0, pix_we},    32'd0);
        check({name, "_pix_addr"},  {26'd0, pix_addr},  32'd0);
        check({name, "_pix_wdata"}, {8'd0, pix_wdata},  32'd0);
        check({name, "_tx_start"},  {31'd0, tx_start},  32'd0);
        check({name, "_tx_len"},    {25'd0, tx_len},    32'd0);
        check({name, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        check({name, "_err_code"},  {30'd0, err_code},  32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Non-header byte in IDLE is ignored, then the two-pixel frame.
        send(8'h33);
        wq.push_back(wr_t'{addr: 6'd0, data: 24'h102030});
        wq.push_back(wr_t'{addr: 6'd1, data: 24'h405060});
        tq.push_back(7'd2);
        send(HDR); send(8'h02);
        send(8'h10); send(8'h20); send(8'h30);
        send(8'h40); send(8'h50); send(8'h60);
`ifdef FRAME_CHECKSUM_EN
        send(8'h72);
`endif
        check("tx_start_2pix", {31'd0, tx_start}, 32'd1);
        serve_tx();

        // Length 0 and length 65 are both rejected; trailing bytes are discarded.
        eq.push_back(2'd1);
        send(HDR); send(8'h00);
        send(8'h10); send(8'h20); send(8'h30);
        drop_select();
        eq.push_back(2'd1);
        send(HDR); send(8'h41);
        send(8'h01); send(8'h02); send(8'h03);
        drop_select();

        // Maximum legal length.
        for (int k = 0; k < 192; k++) pb.push_back(k[7:0]);
        good_frame(64);
        serve_tx();

        // HEADER while transmitter busy: busy-drop, rest of frame ignored.
        pb.push_back(8'h0A); pb.push_back(8'h0B); pb.push_back(8'h0C);
        good_frame(1);
        tx_busy = 1'b1;
        @(negedge clk);
        eq.push_back(2'd0);
        send(HDR);
        send(8'h01); send(8'h11); send(8'h22); send(8'h33);
        tx_busy = 1'b0;
        repeat (2) @(negedge clk);
        drop_select();

        // Abort in PIX with a simultaneous byte that would complete a pixel.
        eq.push_back(2'd2);
        send(HDR); send(8'h03); send(8'h11); send(8'h22);
        frame_active = 1'b0;
        send(8'h33);
        frame_active = 1'b1;
        @(negedge clk);
        check("abort_no_tx_start", {31'd0, tx_start}, 32'd0);

        // Abort while waiting for the length byte.
        eq.push_back(2'd2);
        send(HDR);
        drop_select();

`ifdef FRAME_CHECKSUM_EN
        wq.push_back(wr_t'{addr: 6'd0, data: 24'hAABBCC});
        eq.push_back(2'd3);
        send(HDR); send(8'h01); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hFF);
        repeat (3) @(negedge clk);
        check("csum_err_no_tx_start", {31'd0, tx_start}, 32'd0);
`else
        pb.push_back(8'hAA); pb.push_back(8'hBB); pb.push_back(8'hCC);
        good_frame(1);
        serve_tx();
`endif

        // Reset in the middle of PIX.
        wq.push_back(wr_t'{addr: 6'd0, data: 24'h010203});
        send(HDR); send(8'h02);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        #3 rst = 1'b1;
        #1 check_all_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pb.push_back(8'h07); pb.push_back(8'h08); pb.push_back(8'h09);
        good_frame(1);
        serve_tx();

        repeat (4) @(negedge clk);
        check("write_queue_drained", wq.size(), 32'd0);
        check("err_queue_drained",   eq.size(), 32'd0);
        check("tx_queue_drained",    tq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
